// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit for the E stage; owns the HI/LO registers.
// Results are computed when an operation is accepted and committed after a fixed latency.
module md_unit #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MULT = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_DIV  = CNT_W'(DIV_CYCLES);
    localparam logic [WIDTH-1:0] W_ZERO   = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] W_ONE    = WIDTH'(1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t             state_r, next_state_s;
    logic [CNT_W-1:0]   cnt_r, cnt_nx_s;
    logic [WIDTH-1:0]   hi_r, hi_nx_s, lo_r, lo_nx_s;
    logic [WIDTH-1:0]   pend_hi_r, pend_hi_nx_s, pend_lo_r, pend_lo_nx_s;
    logic               pend_skip_r, pend_skip_nx_s;
    logic               busy_r, done_r, done_nx_s;

    logic                 mul_signed_s;
    logic [2*WIDTH-1:0]   mul_a_s, mul_b_s, prod_s;
    logic                 div_signed_s, rs_neg_s, rt_neg_s, div_zero_s;
    logic [WIDTH-1:0]     div_a_s, div_b_s, div_b_safe_s, q_mag_s, r_mag_s, quot_s, rem_s;

    // Shared multiplier: sign- or zero-extend to 2*WIDTH, keep the low 2*WIDTH bits.
    always_comb begin
        mul_signed_s = (op == OP_MULT);
        if (mul_signed_s) begin
            mul_a_s = {{WIDTH{rs_val[WIDTH-1]}}, rs_val};
            mul_b_s = {{WIDTH{rt_val[WIDTH-1]}}, rt_val};
        end else begin
            mul_a_s = {W_ZERO, rs_val};
            mul_b_s = {W_ZERO, rt_val};
        end
        prod_s = mul_a_s * mul_b_s;
    end

    // Shared divider on magnitudes; INT_MIN / -1 falls out as INT_MIN rem 0.
    always_comb begin
        div_signed_s = (op == OP_DIV);
        rs_neg_s     = div_signed_s & rs_val[WIDTH-1];
        rt_neg_s     = div_signed_s & rt_val[WIDTH-1];
        div_zero_s   = (rt_val == W_ZERO);
        div_a_s      = rs_neg_s ? (W_ZERO - rs_val) : rs_val;
        div_b_s      = rt_neg_s ? (W_ZERO - rt_val) : rt_val;
        div_b_safe_s = div_zero_s ? W_ONE : div_b_s;
        q_mag_s      = div_a_s / div_b_safe_s;
        r_mag_s      = div_a_s % div_b_safe_s;
        quot_s       = (rs_neg_s ^ rt_neg_s) ? (W_ZERO - q_mag_s) : q_mag_s;
        rem_s        = rs_neg_s ? (W_ZERO - r_mag_s) : r_mag_s;
    end

    // Next-state, counter, pending-result and HI/LO update logic.
    always_comb begin
        next_state_s   = state_r;
        cnt_nx_s       = cnt_r;
        hi_nx_s        = hi_r;
        lo_nx_s        = lo_r;
        pend_hi_nx_s   = pend_hi_r;
        pend_lo_nx_s   = pend_lo_r;
        pend_skip_nx_s = pend_skip_r;
        done_nx_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start && !cancel) begin
                    case (op)
                        OP_MULT, OP_MULTU: begin
                            next_state_s   = ST_BUSY;
                            cnt_nx_s       = CNT_MULT;
                            pend_hi_nx_s   = prod_s[2*WIDTH-1:WIDTH];
                            pend_lo_nx_s   = prod_s[WIDTH-1:0];
                            pend_skip_nx_s = 1'b0;
                        end
                        OP_DIV, OP_DIVU: begin
                            next_state_s   = ST_BUSY;
                            cnt_nx_s       = CNT_DIV;
                            pend_hi_nx_s   = rem_s;
                            pend_lo_nx_s   = quot_s;
                            pend_skip_nx_s = div_zero_s;
                        end
                        OP_MTHI: hi_nx_s = rs_val;
                        OP_MTLO: lo_nx_s = rs_val;
                        default: next_state_s = ST_IDLE;
                    endcase
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (cancel) begin
                    next_state_s = ST_IDLE;
                    cnt_nx_s     = CNT_ZERO;
                end else if (cnt_r == CNT_ONE) begin
                    next_state_s = ST_IDLE;
                    cnt_nx_s     = CNT_ZERO;
                    done_nx_s    = 1'b1;
                    if (!pend_skip_r) begin
                        hi_nx_s = pend_hi_r;
                        lo_nx_s = pend_lo_r;
                    end else begin
                        hi_nx_s = hi_r;
                        lo_nx_s = lo_r;
                    end
                end else begin
                    cnt_nx_s = cnt_r - CNT_ONE;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
                cnt_nx_s     = CNT_ZERO;
            end
        endcase
    end

    // State and architectural registers; reset clears everything immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            cnt_r       <= CNT_ZERO;
            hi_r        <= W_ZERO;
            lo_r        <= W_ZERO;
            pend_hi_r   <= W_ZERO;
            pend_lo_r   <= W_ZERO;
            pend_skip_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= next_state_s;
            cnt_r       <= cnt_nx_s;
            hi_r        <= hi_nx_s;
            lo_r        <= lo_nx_s;
            pend_hi_r   <= pend_hi_nx_s;
            pend_lo_r   <= pend_lo_nx_s;
            pend_skip_r <= pend_skip_nx_s;
            busy_r      <= (next_state_s == ST_BUSY);
            done_r      <= done_nx_s;
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign hi   = hi_r;
    assign lo   = lo_r;

endmodule

// File: tb/tb_md_unit.sv
// Directed self-checking bench for md_unit with default parameters.
module tb_md_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        cancel;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_tests = 0;
    int n_fail  = 0;

    md_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .cancel (cancel),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        start  = 1'b1;
        op     = o;
        rs_val = a;
        rt_val = b;
        tick();
        start  = 1'b0;
        op     = 3'd7;
    endtask

    // Ticks from edge k+1 to k+n; busy must hold until the last edge.
    task automatic finish_op(input string tag, input int n, input logic [31:0] eh, input logic [31:0] el);
        for (int i = 1; i < n; i++) begin
            tick();
            chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
        end
        tick();
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
        chk({tag, "_hi"}, hi, eh);
        chk({tag, "_lo"}, lo, el);
    endtask

    initial begin
        reset  = 1'b0;
        start  = 1'b0;
        op     = 3'd7;
        rs_val = 32'd0;
        rt_val = 32'd0;
        cancel = 1'b0;
        #12;
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        reset = 1'b1;
        tick();

        // MULT -2 * 3, with HI/LO hold check just before completion
        issue(3'd0, 32'hFFFFFFFE, 32'd3);
        chk("mult_busy0", {31'd0, busy}, 32'd1);
        for (int i = 1; i < 5; i++) tick();
        chk("mult_hold_hi", hi, 32'd0);
        chk("mult_hold_lo", lo, 32'd0);
        chk("mult_hold_done", {31'd0, done}, 32'd0);
        tick();
        chk("mult_done", {31'd0, done}, 32'd1);
        chk("mult_hi", hi, 32'hFFFFFFFF);
        chk("mult_lo", lo, 32'hFFFFFFFA);
        tick();
        chk("mult_done_pulse", {31'd0, done}, 32'd0);

        issue(3'd1, 32'hFFFFFFFE, 32'd3);
        finish_op("multu", 5, 32'h00000002, 32'hFFFFFFFA);
        issue(3'd2, 32'hFFFFFFF9, 32'd2);
        finish_op("div", 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
        issue(3'd3, 32'd7, 32'd2);
        finish_op("divu", 10, 32'd1, 32'd3);
        issue(3'd2, 32'h80000000, 32'hFFFFFFFF);
        finish_op("div_min", 10, 32'd0, 32'h80000000);

        // Divide by zero leaves preloaded HI/LO untouched
        issue(3'd4, 32'h11, 32'd0);
        chk("mthi_hi", hi, 32'h11);
        issue(3'd5, 32'h22, 32'd0);
        chk("mtlo_lo", lo, 32'h22);
        chk("mtlo_busy", {31'd0, busy}, 32'd0);
        issue(3'd3, 32'd5, 32'd0);
        finish_op("divu0", 10, 32'h11, 32'h22);

        issue(3'd4, 32'hABCD, 32'd0);
        chk("mthi2_hi", hi, 32'hABCD);
        chk("mthi2_busy", {31'd0, busy}, 32'd0);
        chk("mthi2_done", {31'd0, done}, 32'd0);

        // MTLO while busy is ignored
        issue(3'd1, 32'd2, 32'd3);
        issue(3'd5, 32'h55, 32'd0);
        chk("mtlo_busy_lo", lo, 32'h22);
        finish_op("mtlo_ign", 4, 32'd0, 32'd6);

        // Cancel at cycle 3 of MULT
        issue(3'd0, 32'd5, 32'd5);
        tick();
        tick();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        chk("cancel_busy", {31'd0, busy}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("cancel_nodone", {31'd0, done}, 32'd0);
        end
        chk("cancel_hi", hi, 32'd0);
        chk("cancel_lo", lo, 32'd6);

        // start + cancel at the same edge: nothing happens
        cancel = 1'b1;
        issue(3'd4, 32'h99, 32'd0);
        chk("sc_mthi_hi", hi, 32'd0);
        issue(3'd0, 32'd9, 32'd9);
        cancel = 1'b0;
        chk("sc_mult_busy", {31'd0, busy}, 32'd0);
        tick();
        chk("sc_mult_done", {31'd0, done}, 32'd0);

        // Back-to-back: new MULT issued in the done cycle
        issue(3'd0, 32'd2, 32'd3);
        for (int i = 0; i < 5; i++) tick();
        chk("b2b_first_done", {31'd0, done}, 32'd1);
        chk("b2b_first_lo", lo, 32'd6);
        issue(3'd0, 32'd4, 32'd5);
        chk("b2b_accept", {31'd0, busy}, 32'd1);
        finish_op("b2b", 5, 32'd0, 32'd20);

        // Cancel on the completion edge wins
        issue(3'd0, 32'd7, 32'd7);
        for (int i = 0; i < 4; i++) tick();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        chk("cend_done", {31'd0, done}, 32'd0);
        chk("cend_busy", {31'd0, busy}, 32'd0);
        chk("cend_lo", lo, 32'd20);

        // Asynchronous reset in the middle of a divide
        issue(3'd4, 32'h77, 32'd0);
        issue(3'd3, 32'd100, 32'd7);
        tick();
        tick();
        tick();
        #2;
        reset = 1'b0;
        #1;
        chk("mrst_hi", hi, 32'd0);
        chk("mrst_lo", lo, 32'd0);
        chk("mrst_busy", {31'd0, busy}, 32'd0);
        chk("mrst_done", {31'd0, done}, 32'd0);
        tick();
        #2;
        reset = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("post_rst_done", {31'd0, done}, 32'd0);
        end
        chk("post_rst_hi", hi, 32'd0);
        chk("post_rst_lo", lo, 32'd0);
        chk("post_rst_busy", {31'd0, busy}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Parametrised multi-cycle multiply/divide unit for the E stage of the 5-stage MIPS pipeline; owns the HI/LO architectural registers.
- Executes MULT/MULTU/DIV/DIVU with configurable latency and MTHI/MTLO in a single cycle.
- Drives busy so the stall logic can hold any HI/LO-using instruction in D.
- MFHI/MFLO read hi/lo combinationally in E.

Parameters:
WIDTH, 32, operand and HI/LO width
MULT_CYCLES, 5, cycles from multiply start to HI/LO update (>=1)
DIV_CYCLES, 10, cycles from divide start to HI/LO update (>=1)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  E-stage instruction is an md op; sampled on rising edge
op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6-7 no-op
rs_val  in  WIDTH  forwarded rs operand (dividend / multiplicand / MT source)
rt_val  in  WIDTH  forwarded rt operand (divisor / multiplier)
cancel  in  1  discard the in-flight or starting operation (exception hook)
busy  out  1  operation in flight
done  out  1  one-cycle pulse: HI/LO just written by mult/div
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register

Behaviour:
- Reset (reset=0, asynchronous): hi=0, lo=0, busy=0, done=0, counter=0, pending results cleared. Takes effect immediately, including mid-operation.
- IDLE (busy=0):
  - start=1, op in 0-3, cancel=0 at edge k: latch the computed result into the pending HI/LO, load counter with N (MULT_CYCLES or DIV_CYCLES), set busy=1 after edge k.
  - start=1, op=4 (MTHI): hi<=rs_val at edge k. op=5 (MTLO): lo<=rs_val at edge k. busy stays 0; done stays 0.
  - op 6-7: no effect.
- BUSY:
  - Counter decrements each edge.
  - At edge k+N: hi/lo <= pending, busy<=0, done<=1 for exactly the following cycle.
  - hi/lo hold their old values throughout edges k+1 .. k+N-1.
- start while busy=1: ignored, including MTHI/MTLO. Upstream stall logic guarantees this never happens; the unit must still not corrupt state.
- cancel=1:
  - While busy: busy<=0 and counter<=0 at the next edge; hi/lo unchanged; no done pulse.
  - Same edge as start: cancel wins, nothing starts or is written (MTHI/MTLO included).
  - Same edge as completion (counter==1): cancel wins, hi/lo unchanged.
- done and start at the same edge (back-to-back): the new op is accepted because busy is 0 in that cycle.
- Arithmetic:
  - MULT: signed 2*WIDTH product; hi=upper, lo=lower.
  - MULTU: same, unsigned.
  - DIV: signed; quotient truncates toward zero; remainder takes the sign of the dividend; lo=quotient, hi=remainder.
  - DIV special case: rs=INT_MIN, rt=-1 gives lo=INT_MIN, hi=0.
  - DIVU: unsigned.
  - Divisor 0 (DIV/DIVU): operation runs full latency; hi/lo left unchanged at completion; done still pulses.
- Stall contract for the D-stage stall unit: stall an md/MFHI/MFLO/MTHI/MTLO in D when (busy || (start && op<=3)).

Test Plan:
- Reset: drive reset=0 mid-divide at cycle 4 -> hi=lo=0, busy=0, done=0 immediately; stays so after reset release.
- MULT rs=0xFFFFFFFE (-2), rt=3, defaults -> busy=1 for 5 cycles; hi=0xFFFFFFFF, lo=0xFFFFFFFA at edge k+5; done pulses once. MULTU with the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- DIV rs=-7, rt=2 -> after 10 cycles lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU 7/2 -> lo=3, hi=1.
- Special divides: DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0. DIVU x/0 with hi=0x11, lo=0x22 preloaded via MTHI/MTLO -> hi=0x11, lo=0x22 after 10 cycles; done=1.
- MTHI rs=0xABCD -> hi=0xABCD next edge, busy stays 0. MTLO issued while busy -> ignored; lo unchanged at and after completion.
- Cancel: cancel=1 at cycle 3 of MULT -> busy=0 next edge, no done, hi/lo unchanged. start+cancel same edge -> nothing happens. Back-to-back MULT started in the done cycle -> accepted; second result lands MULT_CYCLES later.
